// File: rtl/m72_sample_fetch.sv
// m72_sample_fetch
// Sample-ROM responder for the M72 sound MCU external-bus sample port.
// Holds the byte-loadable, auto-incrementing 16-bit sample address. Serves
// reads from a one-word cache, which is refilled from SDRAM over a single
// read channel. sample_ready stays low while the presented byte does not
// belong to the current address, so the MCU clock enable stalls.

module m72_sample_fetch #(
  parameter logic [24:0] ROM_BASE = 25'h0
) (
  input  logic        CLK_32M,
  input  logic        reset,
  input  logic [1:0]  sample_addr_wr,
  input  logic [7:0]  sample_addr,
  input  logic        sample_inc,
  output logic [7:0]  sample_rom_data,
  output logic        sample_ready,
  output logic [24:0] sdr_addr,
  output logic        sdr_req,
  input  logic        sdr_ack,
  input  logic [15:0] sdr_data
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2
  } state_e;

  // Sample address
  logic [15:0] addr_q;
  logic [15:0] addr_d;
  logic        addr_upd;

  // Fetch FSM state and registered SDRAM outputs
  state_e      state_q;
  logic        sdr_req_q;
  logic [24:0] sdr_addr_q;
  logic [14:0] fetch_word_q;   // word address of the outstanding fetch
  logic        stale_q;        // outstanding fetch no longer matches addr

  // One-word cache
  logic [15:0] cache_word_q;
  logic [14:0] cache_tag_q;
  logic        cache_valid_q;

  // Registered MCU-side outputs
  logic        ready_q;
  logic [7:0]  rom_data_q;

  // Derived conditions
  logic        hit_cur;
  logic        hit_next;
  logic        moved_from_fetch;
  logic        moved_from_cur;
  logic [24:0] fetch_addr;

  // Next address: any byte write takes priority over the increment.
  // NOTE: always_comb assigns every output a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    addr_upd = (|sample_addr_wr) | sample_inc;
    addr_d   = addr_q;
    if (|sample_addr_wr) begin
      if (sample_addr_wr[0]) addr_d[7:0]  = sample_addr;
      if (sample_addr_wr[1]) addr_d[15:8] = sample_addr;
    end else if (sample_inc) begin
      addr_d = addr_q + 16'd1;
    end
  end

  // Cache hit tests for the present address and for the address after this
  // edge, plus the word-movement tests that mark a fetch stale.
  always_comb begin
    hit_cur          = cache_valid_q && (cache_tag_q == addr_q[15:1]);
    hit_next         = cache_valid_q && (cache_tag_q == addr_d[15:1]);
    moved_from_fetch = addr_upd && (addr_d[15:1] != fetch_word_q);
    moved_from_cur   = addr_upd && (addr_d[15:1] != addr_q[15:1]);
    fetch_addr       = ROM_BASE + {9'd0, addr_q[15:1], 1'b0};
  end

  // Address register: loaded a byte at a time or advanced by the MCU.
  // NOTE: clocked state uses non-blocking assignments so every register
  // samples pre-edge values regardless of block ordering.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      addr_q <= 16'h0000;
    end else begin
      addr_q <= addr_d;
    end
  end

  // Fetch FSM: launches a word read on a miss, holds the request until
  // acknowledged and refills the cache unless the address moved meanwhile.
  // NOTE: the cache word and tag are reset alongside the valid bit because
  // sample_rom_data is loaded from cache_word every cycle and must come out
  // of reset as a known value.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      state_q       <= ST_IDLE;
      sdr_req_q     <= 1'b0;
      sdr_addr_q    <= ROM_BASE;
      fetch_word_q  <= 15'd0;
      stale_q       <= 1'b0;
      cache_word_q  <= 16'h0000;
      cache_tag_q   <= 15'd0;
      cache_valid_q <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!hit_cur) begin
            sdr_addr_q   <= fetch_addr;
            fetch_word_q <= addr_q[15:1];
            // An address update on the launch edge itself already leaves
            // this fetch behind, so it starts out stale in that case.
            stale_q      <= moved_from_cur;
            sdr_req_q    <= 1'b1;
            state_q      <= ST_REQ;
          end
        end

        ST_REQ: begin
          if (moved_from_fetch) stale_q <= 1'b1;
          state_q <= ST_WAIT;
        end

        ST_WAIT: begin
          if (moved_from_fetch) stale_q <= 1'b1;
          if (sdr_ack) begin
            sdr_req_q <= 1'b0;
            state_q   <= ST_IDLE;
            if (!stale_q) begin
              cache_word_q  <= sdr_data;
              cache_tag_q   <= fetch_word_q;
              cache_valid_q <= 1'b1;
            end
          end
        end

        default: begin
          sdr_req_q <= 1'b0;
          state_q   <= ST_IDLE;
        end
      endcase
    end
  end

  // MCU-side outputs: byte select from the cached word, and ready only when
  // the cache covers both the present and the post-update address.
  always_ff @(posedge CLK_32M) begin
    if (reset) begin
      ready_q    <= 1'b0;
      rom_data_q <= 8'h00;
    end else begin
      ready_q    <= (state_q == ST_IDLE) && hit_cur && hit_next;
      rom_data_q <= addr_q[0] ? cache_word_q[15:8] : cache_word_q[7:0];
    end
  end

  assign sample_ready    = ready_q;
  assign sample_rom_data = rom_data_q;
  assign sdr_req         = sdr_req_q;
  assign sdr_addr        = sdr_addr_q;

endmodule
